// File: rtl/exu_issue_pkg.sv
// Shared opcode constants and 4-bit ALU operation encoding for the issue stage and the ALU.
package exu_issue_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASS2 = 4'b1010
    } alu_op_e;

    // Register and immediate arithmetic share one table; only the immediate form has no SUB.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic       funct7_5,
                                                input logic       is_imm);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            3'b000: op = (funct7_5 && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/exu_issue_dec.sv
// Combinational decode of opcode/funct fields into ALU operation and operand selection.
module exu_issue_dec
    import exu_issue_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic [DATA_LEN-1:0] pc,
    input  logic [DATA_LEN-1:0] rs1_data,
    input  logic [DATA_LEN-1:0] rs2_data,
    input  logic [DATA_LEN-1:0] imm,
    output logic [DATA_LEN-1:0] src1,
    output logic [DATA_LEN-1:0] src2,
    output logic [3:0]          alu_control,
    output logic                illegal
);

    alu_op_e alu_op;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_op  = ALU_ADD;
        src1    = '0;
        src2    = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_op = alu_from_funct3(funct3, funct7_5, 1'b0);
                src1   = rs1_data;
                src2   = rs2_data;
            end
            OPC_OP_IMM: begin
                alu_op = alu_from_funct3(funct3, funct7_5, 1'b1);
                src1   = rs1_data;
                src2   = imm;
            end
            OPC_LUI: begin
                alu_op = ALU_PASS2;
                src2   = imm;
            end
            OPC_AUIPC: begin
                src1 = pc;
                src2 = imm;
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                src1 = rs1_data;
                src2 = imm;
            end
            OPC_JAL: begin
                src1 = pc;
                src2 = DATA_LEN'(4);
            end
            OPC_BRANCH: begin
                alu_op = ALU_SUB;
                src1   = rs1_data;
                src2   = rs2_data;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign alu_control = alu_op;

endmodule

// File: rtl/exu_issue.sv
// Issue stage: decode on acceptance, then a two-entry (output + skid) buffer toward the EXU.
module exu_issue
    import exu_issue_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          in_opcode,
    input  logic [2:0]          in_funct3,
    input  logic                in_funct7_5,
    input  logic [DATA_LEN-1:0] in_pc,
    input  logic [DATA_LEN-1:0] in_rs1_data,
    input  logic [DATA_LEN-1:0] in_rs2_data,
    input  logic [DATA_LEN-1:0] in_imm,
    input  logic [4:0]          in_rd,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_src1,
    output logic [DATA_LEN-1:0] out_src2,
    output logic [3:0]          out_alu_control,
    output logic [4:0]          out_rd,
    output logic [DATA_LEN-1:0] out_pc,
    output logic                out_illegal
);

    typedef struct packed {
        logic [DATA_LEN-1:0] src1;
        logic [DATA_LEN-1:0] src2;
        logic [3:0]          alu;
        logic [4:0]          rd;
        logic [DATA_LEN-1:0] pc;
        logic                illegal;
    } entry_t;

    entry_t dec_entry;
    entry_t out_q;
    entry_t skid_q;
    logic   out_valid_q;
    logic   skid_valid_q;
    logic   in_fire;
    logic   out_free;

    exu_issue_dec #(.DATA_LEN(DATA_LEN)) u_dec (
        .opcode      (in_opcode),
        .funct3      (in_funct3),
        .funct7_5    (in_funct7_5),
        .pc          (in_pc),
        .rs1_data    (in_rs1_data),
        .rs2_data    (in_rs2_data),
        .imm         (in_imm),
        .src1        (dec_entry.src1),
        .src2        (dec_entry.src2),
        .alu_control (dec_entry.alu),
        .illegal     (dec_entry.illegal)
    );

    assign dec_entry.rd = in_rd;
    assign dec_entry.pc = in_pc;

    // in_ready depends only on the skid flop, so out_ready never reaches it combinationally.
    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too, so every output reads zero while rst_n is low.
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            // NOTE: non-blocking updates let the skid drain and refill read pre-edge values.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (in_fire) begin
                out_q       <= dec_entry;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q       <= dec_entry;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_src1        = out_q.src1;
    assign out_src2        = out_q.src2;
    assign out_alu_control = out_q.alu;
    assign out_rd          = out_q.rd;
    assign out_pc          = out_q.pc;
    assign out_illegal     = out_q.illegal;

endmodule

// File: tb/tb_exu_issue.sv
// Directed bench for exu_issue: decode vector table plus skid, flush and reset sequences.
module tb_exu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_src1;
    logic [31:0] out_src2;
    logic [3:0]  out_alu_control;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exu_issue #(.DATA_LEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_opcode       (in_opcode),
        .in_funct3       (in_funct3),
        .in_funct7_5     (in_funct7_5),
        .in_pc           (in_pc),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .in_imm          (in_imm),
        .in_rd           (in_rd),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_src1        (out_src1),
        .out_src2        (out_src2),
        .out_alu_control (out_alu_control),
        .out_rd          (out_rd),
        .out_pc          (out_pc),
        .out_illegal     (out_illegal)
    );

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // OP add with rs1=val, rs2=0: out_src1 carries val as a tag.
    task automatic offer_tag(input logic [31:0] val);
        in_opcode   = 7'b0110011;
        in_funct3   = 3'b000;
        in_funct7_5 = 1'b0;
        in_pc       = 32'h1000 + val;
        in_rs1_data = val;
        in_rs2_data = 32'd0;
        in_imm      = 32'd0;
        in_rd       = 5'd1;
        in_valid    = 1'b1;
    endtask

    initial begin
        logic [31:0] got[$];
        bit          accepted;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7_5 = 1'b0; in_pc = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_rd = '0;

        //            opc          f3      f7    pc             rs1     rs2     imm            alu      s1             s2             ill
        vecs.push_back('{7'b0110011, 3'b000, 1'b1, 32'h100,       32'd5,  32'd3,  32'd0,         4'b0001, 32'd5,         32'd3,         1'b0});
        vecs.push_back('{7'b0110011, 3'b000, 1'b0, 32'h104,       32'd10, 32'd20, 32'd0,         4'b0000, 32'd10,        32'd20,        1'b0});
        vecs.push_back('{7'b0110011, 3'b101, 1'b1, 32'h108,       32'd11, 32'd2,  32'd0,         4'b0111, 32'd11,        32'd2,         1'b0});
        vecs.push_back('{7'b0110011, 3'b101, 1'b0, 32'h10C,       32'd12, 32'd3,  32'd0,         4'b0110, 32'd12,        32'd3,         1'b0});
        vecs.push_back('{7'b0110011, 3'b111, 1'b0, 32'h110,       32'd13, 32'd4,  32'd0,         4'b1001, 32'd13,        32'd4,         1'b0});
        vecs.push_back('{7'b0110011, 3'b110, 1'b0, 32'h114,       32'd14, 32'd5,  32'd0,         4'b1000, 32'd14,        32'd5,         1'b0});
        vecs.push_back('{7'b0110011, 3'b100, 1'b0, 32'h118,       32'd15, 32'd6,  32'd0,         4'b0101, 32'd15,        32'd6,         1'b0});
        vecs.push_back('{7'b0110011, 3'b001, 1'b0, 32'h11C,       32'd16, 32'd7,  32'd0,         4'b0010, 32'd16,        32'd7,         1'b0});
        vecs.push_back('{7'b0110011, 3'b010, 1'b0, 32'h120,       32'd17, 32'd8,  32'd0,         4'b0011, 32'd17,        32'd8,         1'b0});
        vecs.push_back('{7'b0010011, 3'b000, 1'b1, 32'h124,       32'd1,  32'd99, 32'd7,         4'b0000, 32'd1,         32'd7,         1'b0});
        vecs.push_back('{7'b0010011, 3'b011, 1'b0, 32'h128,       32'd2,  32'd99, 32'hFFFFFFF0,  4'b0100, 32'd2,         32'hFFFFFFF0,  1'b0});
        vecs.push_back('{7'b0010011, 3'b101, 1'b1, 32'h12C,       32'd3,  32'd99, 32'h405,       4'b0111, 32'd3,         32'h405,       1'b0});
        vecs.push_back('{7'b0010111, 3'b000, 1'b0, 32'h80000000,  32'd9,  32'd9,  32'h1000,      4'b0000, 32'h80000000,  32'h1000,      1'b0});
        vecs.push_back('{7'b0110111, 3'b000, 1'b0, 32'h130,       32'd9,  32'd9,  32'hABCDE000,  4'b1010, 32'd0,         32'hABCDE000,  1'b0});
        vecs.push_back('{7'b0000011, 3'b010, 1'b0, 32'h134,       32'd40, 32'd9,  32'd8,         4'b0000, 32'd40,        32'd8,         1'b0});
        vecs.push_back('{7'b0100011, 3'b010, 1'b0, 32'h138,       32'd41, 32'd9,  32'd12,        4'b0000, 32'd41,        32'd12,        1'b0});
        vecs.push_back('{7'b1100111, 3'b000, 1'b0, 32'h13C,       32'd42, 32'd9,  32'd16,        4'b0000, 32'd42,        32'd16,        1'b0});
        vecs.push_back('{7'b1101111, 3'b000, 1'b0, 32'h140,       32'd43, 32'd9,  32'd64,        4'b0000, 32'h140,       32'd4,         1'b0});
        vecs.push_back('{7'b1100011, 3'b000, 1'b0, 32'h144,       32'd44, 32'd45, 32'd20,        4'b0001, 32'd44,        32'd45,        1'b0});
        vecs.push_back('{7'b1111111, 3'b000, 1'b0, 32'h148,       32'd46, 32'd47, 32'd48,        4'b0000, 32'd0,         32'd0,         1'b1});

        // Reset state
        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_src1", out_src1, 32'd0);
        check("rst out_illegal", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;
        tick();

        // Decode table, one instruction at a time with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            in_opcode   = vecs[i].opc;
            in_funct3   = vecs[i].f3;
            in_funct7_5 = vecs[i].f7;
            in_pc       = vecs[i].pc;
            in_rs1_data = vecs[i].rs1;
            in_rs2_data = vecs[i].rs2;
            in_imm      = vecs[i].imm;
            in_rd       = 5'(i + 1);
            in_valid    = 1'b1;
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d alu", i), 32'(out_alu_control), 32'(vecs[i].alu));
            check($sformatf("v%0d src1", i), out_src1, vecs[i].s1);
            check($sformatf("v%0d src2", i), out_src2, vecs[i].s2);
            check($sformatf("v%0d illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
            check($sformatf("v%0d rd", i), 32'(out_rd), 32'(i + 1));
            check($sformatf("v%0d pc", i), out_pc, vecs[i].pc);
        end
        tick();
        check("idle out_valid", 32'(out_valid), 32'd0);

        // Back-pressure: three back-to-back offers with out_ready low
        out_ready = 1'b0;
        offer_tag(32'd100);
        check("bp A in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp A out_valid", 32'(out_valid), 32'd1);
        check("bp A src1", out_src1, 32'd100);
        check("bp after A in_ready", 32'(in_ready), 32'd1);
        offer_tag(32'd101);
        tick();
        check("bp hold src1", out_src1, 32'd100);
        check("bp after B in_ready", 32'(in_ready), 32'd0);
        offer_tag(32'd102);
        tick();
        check("bp C in_ready", 32'(in_ready), 32'd0);
        check("bp hold2 src1", out_src1, 32'd100);
        check("bp hold2 out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            if (out_valid && out_ready) got.push_back(out_src1);
            accepted = in_valid && in_ready;
            tick();
            if (accepted) in_valid = 1'b0;
        end
        check("bp drained count", 32'(got.size()), 32'd3);
        for (int k = 0; k < got.size() && k < 3; k++)
            check($sformatf("bp order %0d", k), got[k], 32'd100 + 32'(k));
        tick();
        check("bp no dup out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // Flush with both entries full and an input on offer
        out_ready = 1'b0;
        offer_tag(32'd200);
        tick();
        offer_tag(32'd201);
        tick();
        check("fl full in_ready", 32'(in_ready), 32'd0);
        offer_tag(32'd202);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl out_valid", 32'(out_valid), 32'd0);
        check("fl in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("fl quiet %0d", c), 32'(out_valid), 32'd0);
        end

        // Flush with one entry held while in_ready is high: the offered input is dropped
        out_ready = 1'b0;
        offer_tag(32'd210);
        tick();
        offer_tag(32'd211);
        check("fl1 in_ready", 32'(in_ready), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl1 out_valid", 32'(out_valid), 32'd0);
        check("fl1 in_ready after", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        check("fl1 quiet", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream with both entries full
        out_ready = 1'b0;
        offer_tag(32'd300);
        tick();
        offer_tag(32'd301);
        tick();
        in_valid = 1'b0;
        check("rs pre out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs out_valid", 32'(out_valid), 32'd0);
        check("rs in_ready", 32'(in_ready), 32'd1);
        check("rs src1", out_src1, 32'd0);
        check("rs pc", out_pc, 32'd0);
        check("rs rd", 32'(out_rd), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rs quiet %0d", c), 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exu_issue.md
EXU_ISSUE -- requirements
Module: ysyx_22041211_exu_issue

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, giving the operand and PC width.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in_valid  in  1  and in_ready  out  1  for the upstream IDU handshake.
REQ-005 SHALL have ports in_opcode  in  7, in_funct3  in  3 and in_funct7_5  in  1  carrying the decoded instruction fields.
REQ-006 SHALL have ports in_pc, in_rs1_data, in_rs2_data and in_imm, each  in  DATA_LEN, carrying the PC, register operands and sign-extended immediate.
REQ-007 SHALL have port in_rd  in  5  destination register index.
REQ-008 SHALL have port flush  in  1  synchronous kill of all held entries.
REQ-009 SHALL have ports out_valid  out  1  and out_ready  in  1  for the downstream ALU/EXU handshake.
REQ-010 SHALL have ports out_src1 and out_src2, each  out  DATA_LEN, carrying the ALU operands.
REQ-011 SHALL have port out_alu_control  out  4  ALU operation select.
REQ-012 SHALL have ports out_rd  out  5  destination register and out_pc  out  DATA_LEN  instruction PC.
REQ-013 SHALL have port out_illegal  out  1  unsupported-opcode flag.

Function
REQ-014 SHALL transfer on the input side when in_valid&&in_ready and on the output side when out_valid&&out_ready.
REQ-015 SHALL decode at input-acceptance time and register the result, so out_valid rises on the cycle after acceptance (latency 1).
REQ-016 SHALL use ALU encoding 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and, 1010 pass-src2.
REQ-017 SHALL map OP (0110011) through funct3: 000 -> add, or sub when funct7_5=1; 001 sll; 010 slt; 011 sltu; 100 xor; 101 -> srl, or sra when funct7_5=1; 110 or; 111 and; operands rs1, rs2.
REQ-018 SHALL map OP-IMM (0010011) as OP except funct3=000 is always add, with src2=imm.
REQ-019 SHALL map LUI to 1010 with src2=imm and src1=0, and AUIPC to add with src1=pc and src2=imm.
REQ-020 SHALL map LOAD, STORE and JALR to add with rs1 and imm, JAL to add with pc and constant 4, and BRANCH to sub with rs1 and rs2.
REQ-021 SHALL map any other opcode to out_illegal=1, alu_control 0000 and zero operands, and still pass it through the handshake.
REQ-022 SHALL hold two entries (output register plus skid register), giving sustained throughput of 1 per cycle with no combinational path from out_ready to in_ready.
REQ-023 SHALL drive in_ready as a registered signal equal to the inverse of skid-occupied.
REQ-024 When out_ready is low and the output register is occupied, SHALL place an accepted input in the skid register and drop in_ready on the next cycle.
REQ-025 On an output transfer with the skid occupied, SHALL move the skid entry to the output register in the same edge and raise in_ready.
REQ-026 SHALL hold output data stable while out_valid=1 and out_ready=0.
REQ-027 SHALL clear both entries at the next edge when flush=1, discard any same-cycle input, and have in_ready=1 afterwards; flush overrides all simultaneous transfers.

Reset
REQ-028 While rst_n=0, SHALL force out_valid=0, skid empty, in_ready=1, and all data outputs including out_illegal to 0.
REQ-029 Reset asserted mid-transfer SHALL lose both entries without producing any partial output.

Structure
REQ-030 SHALL place opcode constants and the 4-bit ALU encoding in a shared package used by this block and the ALU.
REQ-031 SHALL implement decoding in one combinational sub-module, ysyx_22041211_issue_dec, instantiated once ahead of the buffer.

Verification
REQ-032 Bench: OP, funct3=000, funct7_5=1, rs1=5, rs2=3, out_ready=1 -> next cycle out_valid=1, alu 0001, src1=5, src2=3.
REQ-033 Bench: AUIPC, pc=0x80000000, imm=0x1000 -> alu 0000, src1=0x80000000, src2=0x1000; LUI imm=0xABCDE000 -> alu 1010, src2=0xABCDE000.
REQ-034 Bench: out_ready=0 while 3 back-to-back valid inputs are offered -> first two accepted, in_ready=0 on the third; releasing out_ready -> outputs in order with no loss or duplicates.
REQ-035 Bench: flush with both entries full while in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed entries and the offered input never appear at the output.
REQ-036 Bench: opcode 0x7F -> out_illegal=1, alu 0000, src1=src2=0.
REQ-037 Bench: rst_n low mid-stream -> out_valid=0 and in_ready=1 immediately, outputs 0.
